// File: rtl/axil_regfile_s.sv
// ---------------------------------------------------------------------------
// axil_regfile_s
//
// AXI4-Lite slave register bank. It holds NUM_REGS 32-bit read/write
// registers in a window that starts at BASE_ADDR. Writes honour the byte
// strobes. Every register is exported on reg_out. A one-cycle wr_pulse bit
// fires on the same edge on which the new value appears on reg_out.
// Accesses outside the window complete with SLVERR and have no side effects.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axi_aw*            write address channel (awprot ignored)
//   s_axi_w*             write data channel (32-bit data, 4 byte strobes)
//   s_axi_b*             write response channel (OKAY / SLVERR)
//   s_axi_ar*            read address channel (arprot ignored)
//   s_axi_r*             read data channel (OKAY / SLVERR)
//   reg_out              register contents, reg i at [32i+31:32i]
//   wr_pulse             one-cycle pulse per register on write commit
// ---------------------------------------------------------------------------
module axil_regfile_s #(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS     = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                       aclk,
    input  logic                       aresetn,

    input  logic [C_ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,

    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,

    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,

    input  logic [C_ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,

    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,

    output logic [NUM_REGS*32-1:0]     reg_out,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int unsigned             IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [C_ADDR_WIDTH-1:0] BASE        = C_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [C_ADDR_WIDTH-1:0] WIN_BYTES   = C_ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]              RESP_OKAY   = 2'b00;
    localparam logic [1:0]              RESP_SLVERR = 2'b10;

    // -----------------------------------------------------------------------
    // Ready enable: held low in reset and for the first edge after release.
    // -----------------------------------------------------------------------
    logic rdy_en_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_en_reg <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Write channel state
    // -----------------------------------------------------------------------
    logic                    aw_held_reg;
    logic [C_ADDR_WIDTH-1:0] aw_addr_reg;
    logic                    w_held_reg;
    logic [31:0]             w_data_reg;
    logic [3:0]              w_strb_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    commit;

    logic [C_ADDR_WIDTH-1:0] aw_offset;
    logic                    aw_in_range;
    logic [IDX_W-1:0]        aw_idx;

    assign s_axi_awready = rdy_en_reg & ~aw_held_reg & ~bvalid_reg;
    assign s_axi_wready  = rdy_en_reg & ~w_held_reg  & ~bvalid_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid  & s_axi_wready;
    // Both halves of the write are present: this is the commit cycle.
    assign commit = aw_held_reg & w_held_reg;

    // The subtraction wraps for addresses below the base, so the lower bound
    // has to be checked explicitly. The low two address bits fall inside the
    // offset compare and drop out of the index.
    assign aw_offset   = aw_addr_reg - BASE;
    assign aw_in_range = (aw_addr_reg >= BASE) && (aw_offset < WIN_BYTES);
    assign aw_idx      = aw_offset[IDX_W+1:2];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                // Neither channel can be accepted while a response is pending,
                // so these handshakes never overlap with a commit or with B.
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    aw_addr_reg <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= s_axi_wdata;
                    w_strb_reg <= s_axi_wstrb;
                end
                if (bvalid_reg && s_axi_bready) begin
                    bvalid_reg <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register storage, one block per register
    // -----------------------------------------------------------------------
    logic [31:0] reg_vals [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [31:0] value_reg;
            logic        pulse_reg;
            logic        wr_en;

            assign wr_en = commit && aw_in_range && (aw_idx == IDX_W'(gi));

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    value_reg <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= wr_en;
                    for (int k = 0; k < 4; k++) begin
                        if (wr_en && w_strb_reg[k]) begin
                            value_reg[8*k +: 8] <= w_data_reg[8*k +: 8];
                        end
                    end
                end
            end

            assign reg_vals[gi]          = value_reg;
            assign reg_out[32*gi +: 32]  = value_reg;
            assign wr_pulse[gi]          = pulse_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    logic                    rvalid_reg;
    logic [31:0]             rdata_reg;
    logic [1:0]              rresp_reg;
    logic                    ar_hs;
    logic [C_ADDR_WIDTH-1:0] ar_offset;
    logic                    ar_in_range;
    logic [IDX_W-1:0]        ar_idx;

    assign s_axi_arready = rdy_en_reg & ~rvalid_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;

    assign ar_hs       = s_axi_arvalid & s_axi_arready;
    assign ar_offset   = s_axi_araddr - BASE;
    assign ar_in_range = (s_axi_araddr >= BASE) && (ar_offset < WIN_BYTES);
    assign ar_idx      = ar_offset[IDX_W+1:2];

    // The register array is sampled in the AR cycle, so a read that lands in
    // a commit cycle returns the value from before that write.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            if (ar_in_range) begin
                rdata_reg <= reg_vals[ar_idx];
                rresp_reg <= RESP_OKAY;
            end else begin
                rdata_reg <= '0;
                rresp_reg <= RESP_SLVERR;
            end
        end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    // Protection bits carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

endmodule

// File: tb/tb_axil_regfile_s.sv
// ---------------------------------------------------------------------------
// tb_axil_regfile_s
//
// Bench for axil_regfile_s with BASE_ADDR = 0x1000 and eight registers.
// A table of write/read-back vectors is applied in a loop. Hand-written
// sequences then cover the multi-cycle cases: W before AW, a stalled B/R
// channel, a read that collides with a commit, and reset in mid-transaction.
// Expected B/R responses go into queues when the request is driven, and a
// monitor pops and compares them when the handshake occurs.
// ---------------------------------------------------------------------------
module tb_axil_regfile_s;

    localparam int          NREGS = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic                 aclk;
    logic                 aresetn;
    logic [31:0]          s_axi_awaddr;
    logic [2:0]           s_axi_awprot;
    logic                 s_axi_awvalid;
    logic                 s_axi_awready;
    logic [31:0]          s_axi_wdata;
    logic [3:0]           s_axi_wstrb;
    logic                 s_axi_wvalid;
    logic                 s_axi_wready;
    logic [1:0]           s_axi_bresp;
    logic                 s_axi_bvalid;
    logic                 s_axi_bready;
    logic [31:0]          s_axi_araddr;
    logic [2:0]           s_axi_arprot;
    logic                 s_axi_arvalid;
    logic                 s_axi_arready;
    logic [31:0]          s_axi_rdata;
    logic [1:0]           s_axi_rresp;
    logic                 s_axi_rvalid;
    logic                 s_axi_rready;
    logic [NREGS*32-1:0]  reg_out;
    logic [NREGS-1:0]     wr_pulse;

    axil_regfile_s #(
        .C_ADDR_WIDTH (32),
        .NUM_REGS     (NREGS),
        .BASE_ADDR    (BASE)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic [1:0]  b_q [$];
    rsp_t        r_q [$];
    logic [31:0] model [NREGS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: got no event, expected one within 20 cycles", name);
    endtask

    // Response scoreboard: a handshake is seen at the negedge before its edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (b_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL b_unexpected: got bresp %0h, expected no response", s_axi_bresp);
                end else begin
                    logic [1:0] eb;
                    eb = b_q.pop_front();
                    check("bresp", s_axi_bresp, eb);
                    $display("B  resp=%0h", s_axi_bresp);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL r_unexpected: got rdata %0h, expected no response", s_axi_rdata);
                end else begin
                    rsp_t er;
                    er = r_q.pop_front();
                    check("rdata", s_axi_rdata, er.data);
                    check("rresp", s_axi_rresp, er.resp);
                    $display("R  data=%08h resp=%0h", s_axi_rdata, s_axi_rresp);
                end
            end
        end
    end

    // which: 0 = awready&wready, 1 = wready, 2 = awready, 3 = arready
    task automatic wait_ready(input int which, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if ((which == 0 && s_axi_awready && s_axi_wready) ||
                (which == 1 && s_axi_wready) ||
                (which == 2 && s_axi_awready) ||
                (which == 3 && s_axi_arready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    function automatic logic [NREGS-1:0] onehot(input int idx);
        logic [NREGS-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        if (idx >= 0) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
            end
        end
    endfunction

    // Called #1 after the edge on which the last of AW/W was accepted.
    task automatic post_accept(input int idx);
        check("bvalid_in_commit_cycle", s_axi_bvalid, 1'b0);
        check("wr_pulse_in_commit_cycle", wr_pulse, '0);
        @(posedge aclk); #1;
        check("bvalid_after_commit", s_axi_bvalid, 1'b1);
        check("wr_pulse_after_commit", wr_pulse, onehot(idx));
        @(posedge aclk); #1;
        check("wr_pulse_one_cycle", wr_pulse, '0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] bresp, input int idx);
        b_q.push_back(bresp);
        @(posedge aclk); #1;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        wait_ready(0, "aw_w_ready_timeout");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        $display("W  addr=%08h data=%08h strb=%0h", addr, data, strb);
        post_accept(idx);
        model_write(idx, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        rsp_t r;
        r.data = data;
        r.resp = resp;
        r_q.push_back(r);
        @(posedge aclk); #1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        wait_ready(3, "arready_timeout");
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        check("rvalid_one_cycle_after_ar", s_axi_rvalid, 1'b1);
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREGS; i++) begin
            check($sformatf("reg_out[%0d]", i), reg_out[32*i +: 32], model[i]);
        end
    endtask

    typedef struct {
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          idx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected one before the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h04, 32'h1010_1111, 4'hF, 2'b00, 32'h1010_1111, 2'b00, 1};
        vecs[1] = '{32'h08, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678, 2'b00, 2};
        vecs[2] = '{32'h00, 32'hDEAD_BEEF, 4'h5, 2'b00, 32'h00AD_00EF, 2'b00, 0};
        vecs[3] = '{32'h1C, 32'hFFFF_FFFF, 4'h8, 2'b00, 32'hFF00_0000, 2'b00, 7};
        vecs[4] = '{32'h20, 32'h5555_5555, 4'hF, 2'b10, 32'h0000_0000, 2'b10, -1};
        vecs[5] = '{32'h16, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0BAD_F00D, 2'b00, 5};
        vecs[6] = '{32'h04, 32'hAAAA_BBBB, 4'h6, 2'b00, 32'h10AA_BB11, 2'b00, 1};

        for (int i = 0; i < NREGS; i++) model[i] = '0;

        aresetn       = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awprot  = 3'b010;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arprot  = 3'b101;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;

        // Reset state
        #2;
        check("reset_reg_out", reg_out, '0);
        check("reset_wr_pulse", wr_pulse, '0);
        check("reset_bvalid", s_axi_bvalid, 1'b0);
        check("reset_rvalid", s_axi_rvalid, 1'b0);
        check("reset_rdata", s_axi_rdata, '0);
        check("reset_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        check("readies_low_first_cycle", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        @(posedge aclk); #1;
        check("readies_high_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // Table: write then read back, compare the whole bank
        for (int v = 0; v < 7; v++) begin
            do_write(BASE + vecs[v].off, vecs[v].data, vecs[v].strb, vecs[v].bresp, vecs[v].idx);
            do_read(BASE + vecs[v].off, vecs[v].rdata, vecs[v].rresp);
            check_regs();
        end

        // W three cycles ahead of AW, partial strobe on reg2
        b_q.push_back(2'b00);
        @(posedge aclk); #1;
        s_axi_wdata  = 32'hAAAA_5555;
        s_axi_wstrb  = 4'b0011;
        s_axi_wvalid = 1'b1;
        wait_ready(1, "wready_timeout");
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
        check("wready_low_after_w", s_axi_wready, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        s_axi_awaddr  = BASE + 32'h08;
        s_axi_awvalid = 1'b1;
        wait_ready(2, "awready_timeout");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        $display("W  addr=%08h data=aaaa5555 strb=3 (W first)", BASE + 32'h08);
        post_accept(2);
        model_write(2, 32'hAAAA_5555, 4'b0011);
        check("reg2_partial", reg_out[95:64], 32'h1234_5555);

        // Write below the window
        do_write(BASE - 32'h4, 32'h7777_7777, 4'hF, 2'b10, -1);
        check_regs();
        do_read(BASE + 32'h20, 32'h0, 2'b10);

        // B channel stalled for 5 cycles with a second write waiting
        s_axi_bready = 1'b0;
        do_write(BASE + 32'h18, 32'h6666_6666, 4'hF, 2'b00, 6);
        b_q.push_back(2'b00);
        s_axi_awaddr  = BASE + 32'h1C;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'h0707_0707;
        s_axi_wstrb   = 4'hF;
        s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            check("b_stall_bvalid_bresp", {s_axi_bvalid, s_axi_bresp}, 3'b100);
            check("b_stall_readies", {s_axi_awready, s_axi_wready}, 2'b00);
        end
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        check("bvalid_cleared", s_axi_bvalid, 1'b0);
        check("aw_w_ready_after_b", {s_axi_awready, s_axi_wready}, 2'b11);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        post_accept(7);
        model_write(7, 32'h0707_0707, 4'hF);
        check_regs();

        // R channel stalled for 5 cycles
        s_axi_rready = 1'b0;
        do_read(BASE + 32'h18, 32'h6666_6666, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            check("r_stall_rdata", s_axi_rdata, 32'h6666_6666);
            check("r_stall_rvalid_arready", {s_axi_rvalid, s_axi_arready}, 2'b10);
        end
        s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        check("rvalid_cleared", s_axi_rvalid, 1'b0);

        // Read of reg3 in the commit cycle of a write to reg3
        b_q.push_back(2'b00);
        @(posedge aclk); #1;
        s_axi_awaddr  = BASE + 32'h0C;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'hCAFE_0001;
        s_axi_wstrb   = 4'hF;
        s_axi_wvalid  = 1'b1;
        wait_ready(0, "collide_ready_timeout");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        r_q.push_back('{2'b00, 32'h0});
        s_axi_araddr  = BASE + 32'h0C;
        s_axi_arvalid = 1'b1;
        check("collide_arready", s_axi_arready, 1'b1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        check("collide_rvalid", s_axi_rvalid, 1'b1);
        check("collide_bvalid", s_axi_bvalid, 1'b1);
        check("collide_wr_pulse", wr_pulse, onehot(3));
        model_write(3, 32'hCAFE_0001, 4'hF);
        do_read(BASE + 32'h0C, 32'hCAFE_0001, 2'b00);
        check_regs();

        // Reset while a write response is pending
        s_axi_bready = 1'b0;
        do_write(BASE + 32'h10, 32'h4444_4444, 4'hF, 2'b00, 4);
        #3 aresetn = 1'b0;
        #1;
        check("async_bvalid", s_axi_bvalid, 1'b0);
        check("async_reg_out", reg_out, '0);
        check("async_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        b_q.delete();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        check("rel_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        @(posedge aclk); #1;
        check("rel_readies_high", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // Reset with only the address half of a write held
        s_axi_awaddr  = BASE + 32'h10;
        s_axi_awvalid = 1'b1;
        wait_ready(2, "aw_only_timeout");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        check("aw_held_awready", s_axi_awready, 1'b0);
        #3 aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("aw_dropped_awready", s_axi_awready, 1'b1);
        s_axi_wdata  = 32'h9999_9999;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        wait_ready(1, "w_after_drop_timeout");
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk); #1;
            check("dropped_no_bvalid", {s_axi_bvalid, wr_pulse}, '0);
        end
        check_regs();

        check("b_queue_drained", b_q.size(), 0);
        check("r_queue_drained", r_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
